trace_capture: RTL and testbench
================================

Name: trace_capture

Overview:
- Parametrised debug-trace recorder for the 16-bit CPU; the next generation after the simulation-only cpu_monitor.
- Sits beside the cpu instance and taps its DBG_* register-file write and RAM write buses.
- Records write events into an on-chip circular buffer with an armable PC/external trigger and configurable post-trigger depth.
- A bench or debug host reads the frozen trace back through a rd/raddr/rdata port.

Parameters:
- DATA_W, 16: width of register and RAM write data.
- PC_W, 8: width of DBG_pc.
- RAM_AW, 8: width of the RAM write address.
- RF_AW, 4: width of the register-file write address.
- DEPTH, 64: buffer entries; power of two, minimum 4.
- POST_DEPTH, 16: entries captured after the trigger; range 0..DEPTH-1.
- CYCLE_MODE, 0: 0 = capture only cycles with a write; 1 = capture every cycle.

Ports:
- clk, in, 1: system clock; all state changes on the rising edge.
- ext_rst, in, 1: asynchronous reset, active-low.
- arm, in, 1: one-cycle pulse; clears the buffer and enters ARMED.
- trig_ext, in, 1: external trigger, level-sampled.
- trig_pc_en, in, 1: enables the PC-match trigger.
- trig_pc, in, PC_W: PC match value.
- DBG_pc, in, PC_W: PC of the current cycle.
- DBG_wr_rd, in, 1: register-file write strobe.
- DBG_addr_rd, in, RF_AW: register-file write address.
- DBG_wdata_rd, in, DATA_W: register-file write data.
- DBG_ram_wr, in, 1: RAM write strobe.
- DBG_ram_waddr, in, RAM_AW: RAM write address.
- DBG_ram_wdata, in, DATA_W: RAM write data.
- rd, in, 1: readback request.
- raddr, in, log2(DEPTH): readback index; 0 = oldest valid entry.
- rdata, out, ENTRY_W: readback entry.
  - ENTRY_W = 2 + PC_W + RF_AW + DATA_W + RAM_AW + DATA_W.
  - Packing, MSB first: {ram_v, rf_v, pc, rf_addr, rf_data, ram_addr, ram_data}.
- rvalid, out, 1: rdata valid.
- state_o, out, 2: current FSM state encoding.
- count, out, log2(DEPTH)+1: number of valid entries.
- triggered, out, 1: set in POST and DONE.
- wrapped, out, 1: the write pointer has wrapped since arm.

Behaviour:
- Reset (asynchronous, ext_rst low):
  - state = IDLE.
  - Write pointer, count, wrapped, post counter, triggered and rvalid cleared; rdata = 0.
  - Buffer contents undefined.
  - Reset asserted mid-capture aborts immediately to IDLE.
- FSM encoding: IDLE=0, ARMED=1, POST=2, DONE=3.
- arm:
  - Accepted in any state. Next state = ARMED; pointer, count, wrapped and triggered are cleared.
  - The arm cycle itself is not captured.
- Capture condition (cap):
  - CYCLE_MODE=0: cap = DBG_wr_rd | DBG_ram_wr.
  - CYCLE_MODE=1: cap = 1.
  - An entry stores both channels' fields; an inactive channel's fields are stored as 0 with its _v bit 0.
  - A simultaneous register and RAM write therefore lands in one entry.
- Trigger condition (trig) = trig_ext | (trig_pc_en & DBG_pc == trig_pc).
- ARMED:
  - Every cap cycle writes buf[wptr], wptr++ (mod DEPTH), count saturates at DEPTH.
  - Set wrapped when wptr wraps to 0.
  - On trig, the cycle's entry (if cap) is written, post counter = POST_DEPTH, go to POST.
  - If POST_DEPTH=0, go directly to DONE.
- POST:
  - Each cap cycle writes and decrements the post counter; at 0 after the write, go to DONE.
  - trig while in POST is ignored.
- DONE and IDLE: no writes.
- Readback:
  - Valid only in DONE.
  - Physical index = (wrapped ? wptr : 0) + raddr, mod DEPTH.
  - rd in DONE gives rdata/rvalid registered on the next edge (1-cycle latency).
  - rvalid is a single-cycle pulse per rd.
  - rd with raddr >= count returns rdata = 0, rvalid = 1.
  - rd outside DONE returns rvalid = 0, rdata unchanged.
- Back-to-back rd is supported at one per cycle.

Decomposition:
- Shared package trace_pkg holds:
  - the state encodings;
  - ENTRY_W and field-offset localparam functions;
  - the clog2 helper.
- One sub-module, trace_ram: simple dual-port memory (1 write port, 1 registered read port), DEPTH x ENTRY_W, no reset on the array.
- Top-level trace_capture holds the FSM, pointers, trigger logic and packing.

Test Plan:
- Reset then idle: ext_rst=0 for 2 cycles, then release with writes present -> state_o=0, count=0, rvalid=0; no capture.
- Pre-trigger wrap:
  - Stimulus: DEPTH=64, POST_DEPTH=16, arm, 100 reg writes with data = i, trig_ext at i=100, then 20 more writes.
  - Response: DONE after write 116; count=64; wrapped=1; raddr=0 reads data 53; raddr=63 reads data 116, with rf_v=1.
- Simultaneous channels: same cycle DBG_wr_rd=1 (addr 3, 0xBEEF) and DBG_ram_wr=1 (addr 0x20, 0x1234) -> one entry with ram_v=rf_v=1 and both payloads intact.
- PC trigger: trig_pc_en=1, trig_pc=0x42, POST_DEPTH=0 -> DONE on the cycle DBG_pc=0x42 with cap; last entry pc=0x42.
- Mid-capture events:
  - arm in POST -> ARMED, count=0.
  - ext_rst low in POST -> IDLE asynchronously, before the next edge.
- Readback corner cases:
  - rd with raddr=count -> rdata=0, rvalid=1.
  - rd in ARMED -> rvalid=0.
  - Four back-to-back rd -> four consecutive rvalid pulses with matching data.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types and sizing helpers for the trace recorder: state encodings, entry width and field offsets.
// Pure declarations with no latency and no backpressure; imported by trace_capture, trace_ram and the bench.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    // Entry layout, MSB first: {ram_v, rf_v, pc, rf_addr, rf_data, ram_addr, ram_data}
    function automatic int entry_w(input int pc_w, input int rf_aw, input int data_w, input int ram_aw);
        return 2 + pc_w + rf_aw + data_w + ram_aw + data_w;
    endfunction

    function automatic int off_ram_addr(input int data_w);
        return data_w;
    endfunction

    function automatic int off_rf_data(input int data_w, input int ram_aw);
        return data_w + ram_aw;
    endfunction

    function automatic int off_rf_addr(input int data_w, input int ram_aw);
        return 2 * data_w + ram_aw;
    endfunction

    function automatic int off_pc(input int data_w, input int ram_aw, input int rf_aw);
        return 2 * data_w + ram_aw + rf_aw;
    endfunction

    function automatic int off_rf_v(input int data_w, input int ram_aw, input int rf_aw, input int pc_w);
        return 2 * data_w + ram_aw + rf_aw + pc_w;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace buffer store: simple dual-port array, one write port and one registered read port, no array reset.
// Latency: read data appears one edge after re; no backpressure, both ports accept every cycle.
module trace_ram #(
    parameter int AW = 6,
    parameter int W  = 54
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [0:(1 << AW) - 1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/trace_capture.sv
// Debug-trace recorder: captures CPU register/RAM write events into a circular buffer around a trigger.
// Latency: capture in the event cycle, readback 1 cycle after rd; no backpressure, rd accepted every cycle.
module trace_capture
    import trace_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int PC_W       = 8,
    parameter int RAM_AW     = 8,
    parameter int RF_AW      = 4,
    parameter int DEPTH      = 64,
    parameter int POST_DEPTH = 16,
    parameter int CYCLE_MODE = 0
) (
    input  logic                                            clk,
    input  logic                                            ext_rst,
    input  logic                                            arm,
    input  logic                                            trig_ext,
    input  logic                                            trig_pc_en,
    input  logic [PC_W-1:0]                                 trig_pc,
    input  logic [PC_W-1:0]                                 DBG_pc,
    input  logic                                            DBG_wr_rd,
    input  logic [RF_AW-1:0]                                DBG_addr_rd,
    input  logic [DATA_W-1:0]                               DBG_wdata_rd,
    input  logic                                            DBG_ram_wr,
    input  logic [RAM_AW-1:0]                               DBG_ram_waddr,
    input  logic [DATA_W-1:0]                               DBG_ram_wdata,
    input  logic                                            rd,
    input  logic [clog2(DEPTH)-1:0]                         raddr,
    output logic [entry_w(PC_W, RF_AW, DATA_W, RAM_AW)-1:0] rdata,
    output logic                                            rvalid,
    output logic [1:0]                                      state_o,
    output logic [clog2(DEPTH):0]                           count,
    output logic                                            triggered,
    output logic                                            wrapped
);

    localparam int AW = clog2(DEPTH);
    localparam int EW = entry_w(PC_W, RF_AW, DATA_W, RAM_AW);
    localparam logic [AW:0]   FULL      = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] POST_INIT = AW'(POST_DEPTH);

    state_t          state;
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   post_cnt;
    logic            cap;
    logic            trig;
    logic            we;
    logic            rd_ok;
    logic            rd_zero;
    logic [AW-1:0]   phys;
    logic [EW-1:0]   entry;
    logic [EW-1:0]   ram_q;

    assign cap  = (CYCLE_MODE != 0) | DBG_wr_rd | DBG_ram_wr;
    assign trig = trig_ext | (trig_pc_en & (DBG_pc == trig_pc));
    assign we   = !arm && cap && (state == ST_ARMED || state == ST_POST);

    // Inactive channel fields are zeroed so a stale bus value never reads back as data.
    assign entry = {DBG_ram_wr, DBG_wr_rd, DBG_pc,
                    DBG_wr_rd  ? DBG_addr_rd   : {RF_AW{1'b0}},
                    DBG_wr_rd  ? DBG_wdata_rd  : {DATA_W{1'b0}},
                    DBG_ram_wr ? DBG_ram_waddr : {RAM_AW{1'b0}},
                    DBG_ram_wr ? DBG_ram_wdata : {DATA_W{1'b0}}};

    assign rd_ok = rd && (state == ST_DONE);
    assign phys  = (wrapped ? wptr : {AW{1'b0}}) + raddr;

    trace_ram #(.AW(AW), .W(EW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wptr),
        .wdata (entry),
        .re    (rd_ok),
        .raddr (phys),
        .rdata (ram_q)
    );

    // rd_zero masks the un-reset RAM output after reset and for out-of-range reads.
    assign rdata     = rd_zero ? {EW{1'b0}} : ram_q;
    assign state_o   = state;
    assign triggered = (state == ST_POST) || (state == ST_DONE);

    always_ff @(posedge clk or negedge ext_rst) begin
        if (!ext_rst) begin
            rvalid  <= 1'b0;
            rd_zero <= 1'b1;
        end else begin
            rvalid <= rd_ok;
            if (rd_ok) rd_zero <= ({1'b0, raddr} >= count);
        end
    end

    always_ff @(posedge clk or negedge ext_rst) begin
        if (!ext_rst) begin
            state    <= ST_IDLE;
            wptr     <= '0;
            count    <= '0;
            wrapped  <= 1'b0;
            post_cnt <= '0;
        end else if (arm) begin
            state    <= ST_ARMED;
            wptr     <= '0;
            count    <= '0;
            wrapped  <= 1'b0;
            post_cnt <= '0;
        end else begin
            if (we) begin
                wptr <= wptr + 1'b1;
                if (count != FULL) count <= count + 1'b1;
                if (&wptr) wrapped <= 1'b1;
            end
            case (state)
                ST_ARMED: begin
                    if (trig) begin
                        if (POST_DEPTH == 0) begin
                            state <= ST_DONE;
                        end else begin
                            post_cnt <= POST_INIT;
                            state    <= ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (cap) begin
                        post_cnt <= post_cnt - 1'b1;
                        if (post_cnt == AW'(1)) state <= ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_trace_capture.sv
// Bench for trace_capture: two instances (post depth 16 and 0) share randomized stimulus,
// checked every cycle against a history-based reference model plus directed corner cases.
module tb_trace_capture;
    import trace_pkg::*;

    localparam int DEPTH  = 64;
    localparam int PC_W   = 8;
    localparam int RF_AW  = 4;
    localparam int RAM_AW = 8;
    localparam int DATA_W = 16;
    localparam int AW     = clog2(DEPTH);
    localparam int EW     = entry_w(PC_W, RF_AW, DATA_W, RAM_AW);
    localparam int O_RAM_A = off_ram_addr(DATA_W);
    localparam int O_RF_D  = off_rf_data(DATA_W, RAM_AW);
    localparam int O_RF_A  = off_rf_addr(DATA_W, RAM_AW);
    localparam int O_PC    = off_pc(DATA_W, RAM_AW, RF_AW);
    localparam int O_RFV   = off_rf_v(DATA_W, RAM_AW, RF_AW, PC_W);
    localparam int HN      = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              ext_rst = 1'b0;
    logic              arm = 1'b0, trig_ext = 1'b0, trig_pc_en = 1'b0;
    logic [PC_W-1:0]   trig_pc = '0, dbg_pc = '0;
    logic              wr_rd = 1'b0, ram_wr = 1'b0, rd = 1'b0;
    logic [RF_AW-1:0]  addr_rd = '0;
    logic [DATA_W-1:0] wdata_rd = '0, ram_wdata = '0;
    logic [RAM_AW-1:0] ram_waddr = '0;
    logic [AW-1:0]     raddr = '0;

    logic [EW-1:0] rdata_o [2];
    logic          rvalid_o [2];
    logic [1:0]    state_o [2];
    logic [AW:0]   count_o [2];
    logic          trig_o [2];
    logic          wrap_o [2];

    trace_capture #(.POST_DEPTH(16)) u_dut (
        .clk(clk), .ext_rst(ext_rst), .arm(arm), .trig_ext(trig_ext),
        .trig_pc_en(trig_pc_en), .trig_pc(trig_pc), .DBG_pc(dbg_pc),
        .DBG_wr_rd(wr_rd), .DBG_addr_rd(addr_rd), .DBG_wdata_rd(wdata_rd),
        .DBG_ram_wr(ram_wr), .DBG_ram_waddr(ram_waddr), .DBG_ram_wdata(ram_wdata),
        .rd(rd), .raddr(raddr), .rdata(rdata_o[0]), .rvalid(rvalid_o[0]),
        .state_o(state_o[0]), .count(count_o[0]), .triggered(trig_o[0]), .wrapped(wrap_o[0])
    );

    trace_capture #(.POST_DEPTH(0)) u_dut0 (
        .clk(clk), .ext_rst(ext_rst), .arm(arm), .trig_ext(trig_ext),
        .trig_pc_en(trig_pc_en), .trig_pc(trig_pc), .DBG_pc(dbg_pc),
        .DBG_wr_rd(wr_rd), .DBG_addr_rd(addr_rd), .DBG_wdata_rd(wdata_rd),
        .DBG_ram_wr(ram_wr), .DBG_ram_waddr(ram_waddr), .DBG_ram_wdata(ram_wdata),
        .rd(rd), .raddr(raddr), .rdata(rdata_o[1]), .rvalid(rvalid_o[1]),
        .state_o(state_o[1]), .count(count_o[1]), .triggered(trig_o[1]), .wrapped(wrap_o[1])
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: full history of captured entries since arm; the buffer is its last DEPTH items.
    int            mst [2];
    int            mpost [2];
    int            nh [2];
    logic [EW-1:0] hist [2][HN];
    logic [EW-1:0] exp_rdata [2];
    logic          exp_rvalid [2];

    function automatic int post_depth(input int k);
        return (k == 0) ? 16 : 0;
    endfunction

    function automatic int mcount(input int k);
        return (nh[k] < DEPTH) ? nh[k] : DEPTH;
    endfunction

    function automatic logic [EW-1:0] cur_entry();
        logic [EW-1:0] e;
        e = '0;
        e[O_PC +: PC_W] = dbg_pc;
        if (wr_rd) begin
            e[O_RFV] = 1'b1;
            e[O_RF_A +: RF_AW] = addr_rd;
            e[O_RF_D +: DATA_W] = wdata_rd;
        end
        if (ram_wr) begin
            e[O_RFV + 1] = 1'b1;
            e[O_RAM_A +: RAM_AW] = ram_waddr;
            e[0 +: DATA_W] = ram_wdata;
        end
        return e;
    endfunction

    task automatic model_edge(input int k);
        int  c;
        logic cap, trig;
        if (!ext_rst) begin
            mst[k] = 0; nh[k] = 0; mpost[k] = 0;
            exp_rvalid[k] = 1'b0; exp_rdata[k] = '0;
            return;
        end
        exp_rvalid[k] = 1'b0;
        if (rd && mst[k] == 3) begin
            c = mcount(k);
            exp_rvalid[k] = 1'b1;
            exp_rdata[k] = (int'(raddr) < c) ? hist[k][(nh[k] - c + int'(raddr)) % HN] : '0;
        end
        cap  = wr_rd | ram_wr;
        trig = trig_ext | (trig_pc_en && dbg_pc == trig_pc);
        if (arm) begin
            mst[k] = 1; nh[k] = 0;
        end else if (mst[k] == 1) begin
            if (cap) begin hist[k][nh[k] % HN] = cur_entry(); nh[k]++; end
            if (trig) begin
                if (post_depth(k) == 0) mst[k] = 3;
                else begin mpost[k] = post_depth(k); mst[k] = 2; end
            end
        end else if (mst[k] == 2 && cap) begin
            hist[k][nh[k] % HN] = cur_entry(); nh[k]++;
            mpost[k]--;
            if (mpost[k] == 0) mst[k] = 3;
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            chk_eq($sformatf("state%0d", k), state_o[k], mst[k]);
            chk_eq($sformatf("count%0d", k), count_o[k], mcount(k));
            chk_eq($sformatf("wrapped%0d", k), wrap_o[k], nh[k] >= DEPTH);
            chk_eq($sformatf("triggered%0d", k), trig_o[k], mst[k] >= 2);
            chk_eq($sformatf("rvalid%0d", k), rvalid_o[k], exp_rvalid[k]);
            chk_eq($sformatf("rdata%0d", k), rdata_o[k], exp_rdata[k]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_outputs();
    endtask

    task automatic idle_bus();
        arm = 1'b0; trig_ext = 1'b0; rd = 1'b0; wr_rd = 1'b0; ram_wr = 1'b0;
    endtask

    task automatic rand_bus();
        dbg_pc    = PC_W'($urandom);
        wr_rd     = 1'($urandom);
        addr_rd   = RF_AW'($urandom);
        wdata_rd  = DATA_W'($urandom);
        ram_wr    = 1'($urandom);
        ram_waddr = RAM_AW'($urandom);
        ram_wdata = DATA_W'($urandom);
    endtask

    initial begin
        logic [EW-1:0] e_exp;
        int guard;
        for (int k = 0; k < 2; k++) begin
            mst[k] = 0; mpost[k] = 0; nh[k] = 0;
            exp_rvalid[k] = 1'b0; exp_rdata[k] = '0;
        end

        // Reset held with bus activity, then idle after release: nothing captured.
        ext_rst = 1'b0;
        for (int i = 0; i < 2; i++) begin rand_bus(); wr_rd = 1'b1; tick(); end
        ext_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin rand_bus(); wr_rd = 1'b1; tick(); end
        chk_eq("idle_state", state_o[0], 0);
        chk_eq("idle_count", count_o[0], 0);
        chk_eq("idle_rvalid", rvalid_o[0], 0);

        // Pre-trigger wrap: writes 1..120, trigger on write 100.
        idle_bus(); arm = 1'b1; tick(); arm = 1'b0;
        for (int i = 1; i <= 120; i++) begin
            rand_bus(); wr_rd = 1'b1; ram_wr = 1'b0; wdata_rd = DATA_W'(i);
            trig_ext = (i == 100);
            tick();
            if (i == 115) chk_eq("post_before_done", state_o[0], 2);
            if (i == 116) chk_eq("done_after_116", state_o[0], 3);
        end
        idle_bus();
        chk_eq("wrap_count", count_o[0], 64);
        chk_eq("wrap_flag", wrap_o[0], 1);
        rd = 1'b1; raddr = 0; tick();
        chk_eq("oldest_data", rdata_o[0][O_RF_D +: DATA_W], 53);
        raddr = 63; tick();
        chk_eq("newest_data", rdata_o[0][O_RF_D +: DATA_W], 116);
        chk_eq("newest_rfv", rdata_o[0][O_RFV], 1);
        rd = 1'b0; tick();

        // Simultaneous channels, random traffic, trigger, run to DONE.
        arm = 1'b1; tick(); arm = 1'b0;
        dbg_pc = 8'h11; wr_rd = 1'b1; addr_rd = 4'h3; wdata_rd = 16'hBEEF;
        ram_wr = 1'b1; ram_waddr = 8'h20; ram_wdata = 16'h1234;
        tick();
        for (int i = 0; i < 25; i++) begin rand_bus(); tick(); end
        rand_bus(); trig_ext = 1'b1; tick(); trig_ext = 1'b0;
        guard = 0;
        while (mst[0] != 3 && guard < 200) begin rand_bus(); tick(); guard++; end
        chk_eq("reach_done", state_o[0], 3);
        idle_bus();
        rd = 1'b1; raddr = 0; tick();
        e_exp = {1'b1, 1'b1, 8'h11, 4'h3, 16'hBEEF, 8'h20, 16'h1234};
        chk_eq("both_channels", rdata_o[0], e_exp);
        raddr = AW'(mcount(0)); tick();
        chk_eq("oob_rdata", rdata_o[0], 0);
        chk_eq("oob_rvalid", rvalid_o[0], 1);
        for (int i = 0; i < 4; i++) begin
            raddr = AW'($urandom_range(mcount(0) - 1, 0));
            tick();
            chk_eq("b2b_rvalid", rvalid_o[0], 1);
        end
        rd = 1'b0; tick();
        chk_eq("rvalid_pulse", rvalid_o[0], 0);

        // PC trigger on 0x42; also rd while ARMED.
        trig_pc_en = 1'b1; trig_pc = 8'h42;
        arm = 1'b1; tick(); arm = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rand_bus(); wr_rd = 1'b1;
            while (dbg_pc == 8'h42) dbg_pc = PC_W'($urandom);
            rd = 1'b1; raddr = AW'($urandom);
            tick();
        end
        chk_eq("rd_in_armed", rvalid_o[0], 0);
        rd = 1'b0;
        rand_bus(); wr_rd = 1'b1; dbg_pc = 8'h42; tick();
        chk_eq("pc_trig_done", state_o[1], 3);
        chk_eq("pc_trig_post", state_o[0], 2);
        idle_bus(); trig_pc_en = 1'b0;
        rd = 1'b1; raddr = AW'(mcount(1) - 1); tick();
        chk_eq("pc_last_entry", rdata_o[1][O_PC +: PC_W], 8'h42);
        rd = 1'b0;

        // arm in POST, then async reset in POST.
        arm = 1'b1; tick(); arm = 1'b0;
        chk_eq("rearm_state", state_o[0], 1);
        chk_eq("rearm_count", count_o[0], 0);
        for (int i = 0; i < 3; i++) begin rand_bus(); wr_rd = 1'b1; tick(); end
        rand_bus(); trig_ext = 1'b1; tick(); trig_ext = 1'b0;
        for (int i = 0; i < 2; i++) begin rand_bus(); wr_rd = 1'b1; tick(); end
        chk_eq("pre_rst_post", state_o[0], 2);
        idle_bus();
        ext_rst = 1'b0;
        #2;
        chk_eq("async_rst_state", state_o[0], 0);
        chk_eq("async_rst_count", count_o[0], 0);
        chk_eq("async_rst_trig", trig_o[0], 0);
        tick();
        ext_rst = 1'b1;
        tick();

        // Random soak: arm/trigger/readback mixed with random traffic.
        trig_pc_en = 1'b1; trig_pc = PC_W'($urandom);
        for (int i = 0; i < 600; i++) begin
            rand_bus();
            arm      = ($urandom_range(39, 0) == 0);
            trig_ext = ($urandom_range(19, 0) == 0);
            rd       = ($urandom_range(2, 0) == 0);
            raddr    = AW'($urandom);
            tick();
        end
        idle_bus();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
